axi_fifo_fwft: RTL and testbench
================================

// Module: axi_fifo_fwft
// PURPOSE
//  Parametrised synchronous first-word-fall-through FIFO with valid/ready handshake on both sides.
//  Next generation of axi_fifo_top: generic width and depth, flow control, fill level,
//  almost-full/almost-empty flags and synchronous flush.
//  Sits between the DMA read engine and write engine as the elastic data buffer.
// PARAMETERS
//  DATA_W     32  data word width in bits (>=1)
//  DEPTH      16  number of entries; power of two, >=2
//  AF_MARGIN  2   o_almost_full asserts when count >= DEPTH-AF_MARGIN
//  AE_MARGIN  2   o_almost_empty asserts when count <= AE_MARGIN
// PORTS
//  i_clk           in   1                  clock, all logic rising-edge
//  i_rst_n         in   1                  asynchronous reset, active low
//  i_flush         in   1                  synchronous clear of all contents
//  i_s_valid       in   1                  write side: data valid
//  o_s_ready       out  1                  write side: FIFO can accept
//  i_s_data        in   DATA_W             write data
//  o_m_valid       out  1                  read side: head word valid
//  i_m_ready       in   1                  read side: consumer takes head
//  o_m_data        out  DATA_W             head word (FWFT)
//  o_count         out  $clog2(DEPTH)+1    current fill level, 0..DEPTH
//  o_almost_full   out  1                  see AF_MARGIN
//  o_almost_empty  out  1                  see AE_MARGIN
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): pointers=0, o_count=0, o_m_valid=0, o_almost_empty=1, o_almost_full=0,
//    o_s_ready=0; rst_done flop clears. o_s_ready rises on the first clock edge after i_rst_n
//    deasserts. Memory contents are not reset.
//  - Pointers: wr_ptr/rd_ptr are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); MSB is the wrap bit.
//    empty = (wr_ptr==rd_ptr); full = addr equal and wrap bits differ; count = wr_ptr-rd_ptr mod 2^(ADDR_W+1).
//  - Write handshake: push = i_s_valid & o_s_ready. o_s_ready = rst_done & ~full (combinational).
//    i_s_valid while full is held off, never dropped or overwritten.
//  - Read handshake: pop = o_m_valid & i_m_ready. o_m_valid = ~empty. o_m_data = mem[rd_ptr addr],
//    combinational read. o_m_data is don't-care while o_m_valid=0.
//  - Latency: word pushed at edge N is valid on o_m_data/o_m_valid after edge N (1 cycle empty->valid).
//  - Simultaneous push & pop: both pointers advance, count unchanged; legal at any non-empty,
//    non-full level. When empty, only push occurs (o_m_valid=0). When full, only pop occurs
//    (o_s_ready=0); freed slot is visible as o_s_ready=1 the next cycle.
//  - Flush: i_flush=1 at an edge sets wr_ptr=rd_ptr=0; it dominates push and pop in the same cycle
//    (that push is discarded). o_s_ready stays 1 during flush.
//  - Flags: combinational from count. count==DEPTH <=> full; count==0 <=> empty.
//  - Wrap-around: pointers roll over modulo 2^(ADDR_W+1) with no lost or duplicated data.
//  - Reset mid-transfer: everything returns to reset values immediately; no partial handshakes survive.
//  - Assertions (sim only): no push when full, no pop when empty, count<=DEPTH, DEPTH power of two.
// STRUCTURE
//  - axi_dma_pkg: localparam helper function for ADDR_W, typedef fifo_ptr_t generated per
//    instance via parameter (kept local); the package holds DATA_W default constant DMA_DATA_W=32.
//  - Sub-module fifo_ram_2p: DEPTH x DATA_W register array, 1 synchronous write port,
//    1 asynchronous read port. Top holds pointers, handshake, flags and flush.
// TESTING (bench: DATA_W=32, DEPTH=8, AF_MARGIN=2, AE_MARGIN=2)
//  1 Reset: hold i_rst_n=0 for 5 cycles, then release -> o_s_ready=0 during reset, 1 one edge
//    after release; o_m_valid=0, o_count=0, o_almost_empty=1.
//  2 Fill/drain: push 1..8 with i_m_ready=0 -> o_count=8, o_s_ready=0, o_almost_full=1 from count 6;
//    9th word (99) held, not accepted; then drain -> reads 1..8 in order, o_m_valid=0 after the 8th.
//  3 FWFT latency: empty, push 0xA5A5A5A5 at edge N -> o_m_valid=1, o_m_data=0xA5A5A5A5 after N.
//  4 Streaming: i_s_valid=1, i_m_ready=1 continuously for 40 words 0..39 -> in-order output,
//    pointers wrap 5 times, o_count constant at 1 after fill.
//  5 Full + simultaneous pop: full at 8, assert i_m_ready and i_s_valid -> pop only that cycle,
//    o_s_ready=1 next cycle, count returns to 8 after the following push.
//  6 Flush: 5 words stored, i_flush=1 with concurrent push of 0x77 -> o_count=0, o_m_valid=0 next
//    cycle; 0x77 never appears at the output.

Source files
------------

// File: rtl/axi_dma_pkg.sv
// Shared constants and helpers for the DMA datapath blocks.
package axi_dma_pkg;

  // Default data word width of the DMA datapath.
  localparam int DMA_DATA_W = 32;

  // Address width needed to index a buffer of the given depth (at least one bit).
  function automatic int fifo_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram_2p
  import axi_dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming word; contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/axi_fifo_fwft.sv
// First-word-fall-through FIFO with valid/ready on both sides, fill level,
// almost-full/almost-empty flags and synchronous flush.
module axi_fifo_fwft
  import axi_dma_pkg::*;
#(
  parameter int DATA_W    = DMA_DATA_W,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  input  logic [DATA_W-1:0]          i_s_data,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic [DATA_W-1:0]          o_m_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_almost_full,
  output logic                       o_almost_empty
);

  localparam int ADDR_W = fifo_addr_w(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [ADDR_W:0] fifo_ptr_t;

  localparam fifo_ptr_t AF_LEVEL = fifo_ptr_t'(DEPTH - AF_MARGIN);
  localparam fifo_ptr_t AE_LEVEL = fifo_ptr_t'(AE_MARGIN);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axi_fifo_fwft: DEPTH must be a power of two and at least 2");
  end

  fifo_ptr_t wr_ptr;
  fifo_ptr_t rd_ptr;
  fifo_ptr_t count;
  logic      rst_done;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign count = wr_ptr - rd_ptr;

  assign o_s_ready = rst_done & ~full;
  assign o_m_valid = ~empty;
  assign push      = i_s_valid & o_s_ready;
  assign pop       = o_m_valid & i_m_ready;
  // A push coinciding with flush is discarded, so it must not touch storage.
  assign wr_en     = push & ~i_flush;

  assign o_count        = count;
  assign o_almost_full  = (count >= AF_LEVEL);
  assign o_almost_empty = (count <= AE_LEVEL);

  // Advance pointers on handshakes; flush clears them and overrides both sides.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  fifo_ram_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_ptr[ADDR_W-1:0]),
    .i_wdata (i_s_data),
    .i_raddr (rd_ptr[ADDR_W-1:0]),
    .o_rdata (o_m_data)
  );

  a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n) push |-> !full);
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n) pop |-> !empty);
  a_count_range:  assert property (@(posedge i_clk) disable iff (!i_rst_n) count <= fifo_ptr_t'(DEPTH));

endmodule

// File: tb/tb_axi_fifo_fwft.sv
// Scoreboard bench for axi_fifo_fwft (DATA_W=32, DEPTH=8, margins 2).
module tb_axi_fifo_fwft;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_flush;
  logic              i_s_valid;
  logic              o_s_ready;
  logic [DATA_W-1:0] i_s_data;
  logic              o_m_valid;
  logic              i_m_ready;
  logic [DATA_W-1:0] o_m_data;
  logic [3:0]        o_count;
  logic              o_almost_full;
  logic              o_almost_empty;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q [$];

  axi_fifo_fwft #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (2),
    .AE_MARGIN (2)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_s_valid      (i_s_valid),
    .o_s_ready      (o_s_ready),
    .i_s_data       (i_s_data),
    .o_m_valid      (o_m_valid),
    .i_m_ready      (i_m_ready),
    .o_m_data       (o_m_data),
    .o_count        (o_count),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data,
                               input logic mready, input logic flush);
    i_s_valid = valid;
    i_s_data  = data;
    i_m_ready = mready;
    i_flush   = flush;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: at mid-cycle, record accepted words and compare every word the consumer takes.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (i_flush) begin
        exp_q.delete();
      end else begin
        if (o_m_valid && i_m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: unexpected word 0x%0h, expected none", o_m_data);
          end else begin
            checkOutput("scoreboard data", o_m_data, exp_q.pop_front());
          end
        end
        if (i_s_valid && o_s_ready) begin
          exp_q.push_back(i_s_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    i_rst_n = 1'b0;

    // 1: reset
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("reset s_ready", o_s_ready, 1'b0);
    checkOutput("reset m_valid", o_m_valid, 1'b0);
    checkOutput("reset count", o_count, 0);
    checkOutput("reset almost_empty", o_almost_empty, 1'b1);
    checkOutput("reset almost_full", o_almost_full, 1'b0);
    i_rst_n = 1'b1;
    #1;
    checkOutput("release s_ready before edge", o_s_ready, 1'b0);
    tick();
    checkOutput("release s_ready after edge", o_s_ready, 1'b1);

    // 2: fill, hold-off, drain
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b0, 1'b0);
      tick();
      checkOutput("fill count", o_count, k);
      checkOutput("fill almost_full", o_almost_full, (k >= 6));
      checkOutput("fill almost_empty", o_almost_empty, (k <= 2));
    end
    checkOutput("full s_ready", o_s_ready, 1'b0);
    applyStimulus(1'b1, 32'd99, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("held word count", o_count, 8);
    checkOutput("held word s_ready", o_s_ready, 1'b0);
    checkOutput("head before drain", o_m_data, 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (8) tick();
    checkOutput("drained m_valid", o_m_valid, 1'b0);
    checkOutput("drained count", o_count, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // 3: FWFT latency
    applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    #1;
    checkOutput("fwft m_valid before edge", o_m_valid, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("fwft m_valid", o_m_valid, 1'b1);
    checkOutput("fwft m_data", o_m_data, 32'hA5A5_A5A5);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // 4: streaming with wrap-around
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b1, 1'b0);
      tick();
      checkOutput("stream count", o_count, 1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("stream end count", o_count, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // 5: full with simultaneous pop attempt
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    checkOutput("full5 s_ready", o_s_ready, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    tick();
    checkOutput("full5 pop-only count", o_count, 7);
    checkOutput("full5 s_ready next", o_s_ready, 1'b1);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    checkOutput("full5 refill count", o_count, 8);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (8) tick();
    checkOutput("full5 drained count", o_count, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // 6: flush with concurrent push
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    checkOutput("pre-flush count", o_count, 5);
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b1);
    #1;
    checkOutput("flush s_ready", o_s_ready, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("flush count", o_count, 0);
    checkOutput("flush m_valid", o_m_valid, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    checkOutput("post-flush head", o_m_data, 32'h55);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("scoreboard leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
